// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: streaming RV32I field-to-machine-word assembler with address tagging
module rv32i_instr_encoder #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [5:0]           in_op,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    localparam logic [2:0] F_NOP = 3'd0, F_I = 3'd1, F_SH = 3'd2, F_S = 3'd3;
    localparam logic [2:0] F_R = 3'd4, F_U = 3'd5, F_J = 3'd6, F_B = 3'd7;
    localparam logic [31:0] NOP = 32'h0000_0013;
    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, out_addr_q;
    logic [31:0]           out_instr_q, word, enc;
    logic                  out_valid_q, out_last_q, err_q;
    logic [ERR_CNT_W-1:0]  err_count_q;
    logic [2:0]            fmt, f3;
    logic [6:0]            opc, f7;
    logic [3:0]            k;
    logic signed [31:0]    simm;
    logic                  bad, imm_ok, illegal, in_hs, out_hs;
    assign simm      = $signed(in_imm);
    assign in_ready  = state_q == RUN && (!out_valid_q || out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DRAIN && out_hs;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign err       = err_q;
    assign err_count = err_count_q;
    // Map the mnemonic ID onto instruction format, opcode, funct3 and funct7
    always_comb begin
        fmt = F_NOP;
        opc = 7'h13;
        f3  = 3'd0;
        f7  = 7'd0;
        k   = 4'd0;
        bad = 1'b0;
        if (in_op == 6'd0) begin
            fmt = F_NOP;
        end else if (in_op <= 6'd5) begin
            fmt = F_I;
            opc = 7'h03;
            f3  = in_op >= 6'd4 ? in_op[2:0] : in_op[2:0] - 3'd1;
        end else if (in_op <= 6'd11) begin
            fmt = F_I;
            k   = 4'(in_op - 6'd6);
            f3  = k == 4'd0 ? 3'd0 : k <= 4'd3 ? 3'(k + 4'd1) : 3'(k + 4'd2);
        end else if (in_op <= 6'd14) begin
            fmt = F_SH;
            f3  = in_op == 6'd12 ? 3'd1 : 3'd5;
            f7  = in_op == 6'd14 ? 7'h20 : 7'h00;
        end else if (in_op <= 6'd17) begin
            fmt = F_S;
            opc = 7'h23;
            f3  = 3'(in_op - 6'd15);
        end else if (in_op <= 6'd27) begin
            fmt = F_R;
            opc = 7'h33;
            k   = 4'(in_op - 6'd18);
            f3  = k <= 4'd1 ? 3'd0 : k == 4'd7 ? 3'd5 : k <= 4'd6 ? 3'(k - 4'd1) : 3'(k - 4'd2);
            f7  = (k == 4'd1 || k == 4'd7) ? 7'h20 : 7'h00;
        end else if (in_op == 6'd28) begin
            fmt = F_U;
            opc = 7'h37;
        end else if (in_op == 6'd29) begin
            fmt = F_U;
            opc = 7'h17;
        end else if (in_op == 6'd30) begin
            fmt = F_J;
            opc = 7'h6F;
        end else if (in_op == 6'd31) begin
            fmt = F_I;
            opc = 7'h67;
        end else if (in_op <= 6'd37) begin
            fmt = F_B;
            opc = 7'h63;
            k   = 4'(in_op - 6'd32);
            f3  = k <= 4'd1 ? 3'(k) : 3'(k + 4'd2);
        end else begin
            bad = 1'b1;
        end
    end
    // Assemble the word for the decoded format; anything illegal collapses to NOP
    always_comb begin
        word   = NOP;
        imm_ok = 1'b1;
        case (fmt)
            F_I: begin
                word   = {in_imm[11:0], in_rs1, f3, in_rd, opc};
                imm_ok = simm >= -32'sd2048 && simm <= 32'sd2047;
            end
            F_SH: begin
                word   = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
                imm_ok = in_imm < 32'd32;
            end
            F_S: begin
                word   = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
                imm_ok = simm >= -32'sd2048 && simm <= 32'sd2047;
            end
            F_R: word = {f7, in_rs2, in_rs1, f3, in_rd, opc};
            F_U: begin
                word   = {in_imm[31:12], in_rd, opc};
                imm_ok = in_imm[11:0] == 12'd0;
            end
            F_J: begin
                word   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
                imm_ok = simm >= -32'sd1048576 && simm <= 32'sd1048574 && !in_imm[0];
            end
            F_B: begin
                word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
                imm_ok = simm >= -32'sd4096 && simm <= 32'sd4094 && !in_imm[0];
            end
            default: word = NOP;
        endcase
        illegal = bad || !imm_ok;
        enc     = illegal ? NOP : word;
    end
    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    // FSM next state: start opens a program, the last input drains it, the last output closes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (in_hs && in_last) ? DRAIN : RUN;
            DRAIN:   state_d = out_hs ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    // Output register stage, address counter and error bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= BASE_ADDR;
            out_addr_q  <= BASE_ADDR;
            out_instr_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                addr_q      <= BASE_ADDR;
                err_q       <= 1'b0;
                err_count_q <= '0;
            end
            if (in_hs) begin
                out_instr_q <= enc;
                out_addr_q  <= addr_q;
                out_last_q  <= in_last;
                addr_q      <= addr_q + ADDR_W'(4);
                if (illegal) begin
                    err_q <= 1'b1;
                    if (~&err_count_q) err_count_q <= err_count_q + ERR_CNT_W'(1);
                end
            end
            if (in_hs) out_valid_q <= 1'b1;
            else if (out_hs) out_valid_q <= 1'b0;
        end
    end
endmodule
